// File: rtl/incbank_pkg.sv
// Shared types and helpers for the incrementer register bank.
// Optional sticky overflow is enabled with the INCBANK_OVF_STICKY_EN macro.
package incbank_pkg;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } op_t;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Load beats everything; inc and dec together cancel to a hold.
    function automatic op_t decode_op(input logic writeEn, input logic incEn, input logic decEn);
        op_t op;
        op = OP_HOLD;
        if (writeEn) begin
            op = OP_LOAD;
        end else if (incEn && decEn) begin
            op = OP_HOLD;
        end else if (incEn) begin
            op = OP_INC;
        end else if (decEn) begin
            op = OP_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/inc_register_bank_channel.sv
// One counter channel: value register, limit-aware next-value logic, tc and sticky ovf flops.
// Sticky overflow exists only when INCBANK_OVF_STICKY_EN is defined; otherwise ovf is tied low.
module inc_channel
    import incbank_pkg::*;
#(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clock,
    input  logic             rst,
    input  op_t              op,
    input  logic [WIDTH-1:0] dataIn,
    input  logic [WIDTH-1:0] limit,
    input  logic             ovfClr,
    output logic [WIDTH-1:0] value,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] Step    = WIDTH'(STEP);
    localparam logic [WIDTH:0]   StepExt = {1'b0, Step};
    localparam bit               SatMode = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] valueQ, valueD;
    logic [WIDTH:0]   incSum;
    logic             hitD;
    logic             tcQ;

    always_comb begin
        valueD = valueQ;
        hitD   = 1'b0;
        // One extra bit so value+STEP can never wrap silently before the limit test.
        incSum = {1'b0, valueQ} + StepExt;
        case (op)
            OP_LOAD: valueD = dataIn;
            OP_INC: begin
                if (incSum > {1'b0, limit}) begin
                    hitD   = 1'b1;
                    valueD = SatMode ? limit : '0;
                end else begin
                    valueD = incSum[WIDTH-1:0];
                end
            end
            OP_DEC: begin
                if (valueQ < Step) begin
                    hitD   = 1'b1;
                    valueD = SatMode ? '0 : limit;
                end else begin
                    valueD = valueQ - Step;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            valueQ <= '0;
            tcQ    <= 1'b0;
        end else begin
            valueQ <= valueD;
            tcQ    <= hitD;
        end
    end

    assign value = valueQ;
    assign tc    = tcQ;

`ifdef INCBANK_OVF_STICKY_EN
    logic ovfQ;

    // A new event outranks a clear arriving in the same cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            ovfQ <= 1'b0;
        end else if (hitD) begin
            ovfQ <= 1'b1;
        end else if (ovfClr) begin
            ovfQ <= 1'b0;
        end
    end

    assign ovf = ovfQ;
`else
    logic unusedOvfClr;
    assign unusedOvfClr = ovfClr;
    assign ovf          = 1'b0;
`endif

endmodule

// File: rtl/inc_register_bank.sv
// Bank of NUM_CH loadable up/down counters sharing one programmable limit register.
// Define INCBANK_OVF_STICKY_EN to enable the per-channel sticky overflow flags.
module inc_register_bank
    import incbank_pkg::*;
#(
    parameter int unsigned      WIDTH     = 12,
    parameter int unsigned      NUM_CH    = 4,
    parameter int unsigned      STEP      = 1,
    parameter int unsigned      SATURATE  = MODE_WRAP,
    parameter logic [WIDTH-1:0] LIMIT_RST = '1
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       writeEn,
    input  logic [NUM_CH-1:0]       incEn,
    input  logic [NUM_CH-1:0]       decEn,
    input  logic [NUM_CH*WIDTH-1:0] dataIn,
    input  logic                    limitWe,
    input  logic [WIDTH-1:0]        limitIn,
    input  logic [NUM_CH-1:0]       ovfClr,
    output logic [NUM_CH*WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0]        limitOut,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       ovf
);

    logic [WIDTH-1:0] limitQ;

    // Channels see the old limit during the write cycle.
    always_ff @(posedge clock) begin
        if (rst) begin
            limitQ <= LIMIT_RST;
        end else if (limitWe) begin
            limitQ <= limitIn;
        end
    end

    assign limitOut = limitQ;

    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        op_t chOp;
        assign chOp = decode_op(writeEn[i], incEn[i], decEn[i]);

        inc_channel #(
            .WIDTH    (WIDTH),
            .STEP     (STEP),
            .SATURATE (SATURATE)
        ) uChannel (
            .clock  (clock),
            .rst    (rst),
            .op     (chOp),
            .dataIn (dataIn[i*WIDTH +: WIDTH]),
            .limit  (limitQ),
            .ovfClr (ovfClr[i]),
            .value  (dataOut[i*WIDTH +: WIDTH]),
            .tc     (tc[i]),
            .ovf    (ovf[i])
        );
    end

endmodule

// File: tb/tb_inc_register_bank.sv
// Bench for inc_register_bank: a wrap/STEP=1 instance and a saturate/STEP=3 instance share stimulus.
// Directed table rows plus random traffic, all checked against an arithmetic model of the counters.
module tb_inc_register_bank;

    localparam int W = 12;
    localparam int N = 4;
`ifdef INCBANK_OVF_STICKY_EN
    localparam bit OvfOn = 1'b1;
`else
    localparam bit OvfOn = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   writeEn = '0, incEn = '0, decEn = '0, ovfClr = '0;
    logic [N*W-1:0] dataIn = '0;
    logic           limitWe = 1'b0;
    logic [W-1:0]   limitIn = '0;
    logic [N*W-1:0] dataOutW, dataOutS;
    logic [W-1:0]   limitOutW, limitOutS;
    logic [N-1:0]   tcW, tcS, ovfW, ovfS;

    always #5 clock = ~clock;

    inc_register_bank #(.WIDTH(W), .NUM_CH(N), .STEP(1), .SATURATE(0)) uDutW (
        .clock(clock), .rst(rst), .writeEn(writeEn), .incEn(incEn), .decEn(decEn),
        .dataIn(dataIn), .limitWe(limitWe), .limitIn(limitIn), .ovfClr(ovfClr),
        .dataOut(dataOutW), .limitOut(limitOutW), .tc(tcW), .ovf(ovfW)
    );

    inc_register_bank #(.WIDTH(W), .NUM_CH(N), .STEP(3), .SATURATE(1)) uDutS (
        .clock(clock), .rst(rst), .writeEn(writeEn), .incEn(incEn), .decEn(decEn),
        .dataIn(dataIn), .limitWe(limitWe), .limitIn(limitIn), .ovfClr(ovfClr),
        .dataOut(dataOutS), .limitOut(limitOutS), .tc(tcS), .ovf(ovfS)
    );

    // Model state, index 0 = wrap instance, 1 = saturate instance.
    int mVal [2][N];
    int mLim [2];
    bit mTc  [2][N];
    bit mOvf [2][N];
    int nVec = 0;
    int nBad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void modelStep();
        int step, lim, v;
        bit sat, hit;
        for (int d = 0; d < 2; d++) begin
            step = (d == 1) ? 3 : 1;
            sat  = (d == 1);
            lim  = mLim[d];
            for (int c = 0; c < N; c++) begin
                v   = mVal[d][c];
                hit = 1'b0;
                if (rst) begin
                    v = 0;
                end else if (writeEn[c]) begin
                    v = int'(dataIn[c*W +: W]);
                end else if (incEn[c] && !decEn[c]) begin
                    if (v + step > lim) begin
                        hit = 1'b1;
                        v   = sat ? lim : 0;
                    end else begin
                        v = v + step;
                    end
                end else if (decEn[c] && !incEn[c]) begin
                    if (v < step) begin
                        hit = 1'b1;
                        v   = sat ? 0 : lim;
                    end else begin
                        v = v - step;
                    end
                end
                mVal[d][c] = v;
                mTc[d][c]  = hit;
                mOvf[d][c] = !rst && OvfOn && (hit || (mOvf[d][c] && !ovfClr[c]));
            end
            mLim[d] = rst ? 'hFFF : (limitWe ? int'(limitIn) : lim);
        end
    endfunction

    task automatic compareAll();
        for (int c = 0; c < N; c++) begin
            check($sformatf("valW[%0d]", c), 64'(dataOutW[c*W +: W]), 64'(mVal[0][c]));
            check($sformatf("valS[%0d]", c), 64'(dataOutS[c*W +: W]), 64'(mVal[1][c]));
            check($sformatf("tcW[%0d]", c), 64'(tcW[c]), 64'(mTc[0][c]));
            check($sformatf("tcS[%0d]", c), 64'(tcS[c]), 64'(mTc[1][c]));
            check($sformatf("ovfW[%0d]", c), 64'(ovfW[c]), 64'(mOvf[0][c]));
            check($sformatf("ovfS[%0d]", c), 64'(ovfS[c]), 64'(mOvf[1][c]));
        end
        check("limitW", 64'(limitOutW), 64'(mLim[0]));
        check("limitS", 64'(limitOutS), 64'(mLim[1]));
    endtask

    // Inputs change only just after a rising edge; the model consumes them before the next one.
    task automatic cycle();
        modelStep();
        @(posedge clock);
        #1;
        compareAll();
    endtask

    task automatic idle();
        rst = 1'b0; writeEn = '0; incEn = '0; decEn = '0; ovfClr = '0;
        dataIn = '0; limitWe = 1'b0; limitIn = '0;
    endtask

    typedef struct {
        logic [N-1:0]   we, inc, dec, clr;
        logic [N*W-1:0] data;
        bit             lwe;
        logic [W-1:0]   lin;
        int             d, ch, expVal, expLim;
        bit             expTc, expOvf;
    } vec_t;

    function automatic vec_t mk(int d, int ch, bit we, bit inc, bit dec, bit clr, int dval,
                                bit lwe, int lin, int ev, bit etc, bit eovf, int elim);
        vec_t r;
        r.we = '0; r.inc = '0; r.dec = '0; r.clr = '0; r.data = '0;
        r.we[ch] = we; r.inc[ch] = inc; r.dec[ch] = dec; r.clr[ch] = clr;
        r.data[ch*W +: W] = W'(dval);
        r.lwe = lwe; r.lin = W'(lin);
        r.d = d; r.ch = ch; r.expVal = ev; r.expTc = etc; r.expOvf = eovf; r.expLim = elim;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        // Wrap, STEP=1, limit 5 on channel 0 of the wrap instance.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     1, 5,  0,     0, 0, 5));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4,     0, 0,  4,     0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,     0, 0,  5,     0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,     0, 0,  0,     1, 1, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,     0, 0,  0,     0, 1, 5));
        // Saturate, STEP=3, limit 10 on channel 0 of the saturate instance (already at 5, ovf set).
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,     1, 10, 5,     0, 1, 10));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 9,     0, 0,  9,     0, 1, 10));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,     0, 0,  10,    1, 1, 10));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0,     0, 0,  10,    1, 1, 10));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 2,     0, 0,  2,     0, 1, 10));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,     0, 0,  0,     1, 1, 10));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,     0, 0,  0,     0, 1, 10));
        // Load beats inc; then inc&dec holds, even above the limit.
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 'h123, 0, 0,  'h123, 0, 0, 10));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0,     0, 0,  'h123, 0, 0, 10));
        // Event and clear together keep ovf; a lone clear drops it.
        tbl.push_back(mk(0, 2, 1, 0, 0, 0, 10,    0, 0,  10,    0, 0, 10));
        tbl.push_back(mk(0, 2, 0, 1, 0, 1, 0,     0, 0,  0,     1, 1, 10));
        tbl.push_back(mk(0, 2, 0, 0, 0, 1, 0,     0, 0,  0,     0, 0, 10));

        // Reset followed by three idle cycles.
        idle();
        rst = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();
        check("rstValW", 64'(dataOutW), 64'(0));
        check("rstValS", 64'(dataOutS), 64'(0));
        check("rstLimW", 64'(limitOutW), 64'('hFFF));
        check("rstLimS", 64'(limitOutS), 64'('hFFF));
        check("rstTc", 64'({tcW, tcS}), 64'(0));
        check("rstOvf", 64'({ovfW, ovfS}), 64'(0));

        foreach (tbl[i]) begin
            writeEn = tbl[i].we; incEn = tbl[i].inc; decEn = tbl[i].dec; ovfClr = tbl[i].clr;
            dataIn = tbl[i].data; limitWe = tbl[i].lwe; limitIn = tbl[i].lin;
            cycle();
            if (tbl[i].d == 1) begin
                check($sformatf("tbl%0d.val", i), 64'(dataOutS[tbl[i].ch*W +: W]), 64'(tbl[i].expVal));
                check($sformatf("tbl%0d.tc", i), 64'(tcS[tbl[i].ch]), 64'(tbl[i].expTc));
                check($sformatf("tbl%0d.ovf", i), 64'(ovfS[tbl[i].ch]), 64'(OvfOn & tbl[i].expOvf));
                check($sformatf("tbl%0d.lim", i), 64'(limitOutS), 64'(tbl[i].expLim));
            end else begin
                check($sformatf("tbl%0d.val", i), 64'(dataOutW[tbl[i].ch*W +: W]), 64'(tbl[i].expVal));
                check($sformatf("tbl%0d.tc", i), 64'(tcW[tbl[i].ch]), 64'(tbl[i].expTc));
                check($sformatf("tbl%0d.ovf", i), 64'(ovfW[tbl[i].ch]), 64'(OvfOn & tbl[i].expOvf));
                check($sformatf("tbl%0d.lim", i), 64'(limitOutW), 64'(tbl[i].expLim));
            end
        end

        // Random traffic; small limits make wrap/saturate events frequent.
        for (int i = 0; i < 600; i++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < N; c++) begin
                writeEn[c] = ($urandom_range(0, 7) == 0);
                incEn[c]   = ($urandom_range(0, 1) == 1);
                decEn[c]   = ($urandom_range(0, 2) == 0);
                ovfClr[c]  = ($urandom_range(0, 9) == 0);
                dataIn[c*W +: W] = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 15))
                                                               : W'($urandom);
            end
            limitWe = ($urandom_range(0, 15) == 0);
            limitIn = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 12)) : W'($urandom);
            cycle();
        end

        // Reset in the middle of counting with every channel incrementing.
        idle();
        limitWe = 1'b1;
        limitIn = 12'd7;
        cycle();
        idle();
        incEn = '1;
        for (int i = 0; i < 9; i++) cycle();
        rst = 1'b1;
        cycle();
        check("midRstValW", 64'(dataOutW), 64'(0));
        check("midRstValS", 64'(dataOutS), 64'(0));
        check("midRstLimW", 64'(limitOutW), 64'('hFFF));
        check("midRstLimS", 64'(limitOutS), 64'('hFFF));
        check("midRstTc", 64'({tcW, tcS}), 64'(0));
        check("midRstOvf", 64'({ovfW, ovfS}), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
